load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 142 ++++++++++++++
 tb/tb_load_store_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns EX-stage memory requests into single-beat bus
// transactions with byte lanes, load alignment and a bus timeout.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned half/word accesses).
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic [2:0]  ld_trim_ctl,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [7:0]  cnt;
    logic [1:0]  off;
    logic [2:0]  trim;
    logic [1:0]  acc_off;
    logic [3:0]  acc_be;
    logic [31:0] acc_wdata;
    logic [2:0]  acc_trim;
    logic        trap;
    logic        timed_out;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign mem_valid = (state == ISSUE);
    assign timed_out = (state != IDLE) && (cnt == CNT_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
    assign trap = misalign;
`else
    assign trap = 1'b0;
`endif

    // Request decode: lane offset (masked for half/word), enables, replicated data, extender code
    always_comb begin
        acc_off   = 2'b00;
        acc_be    = 4'b1111;
        acc_wdata = req_wdata;
        acc_trim  = 3'b000;
        case (req_size)
            2'b00: begin
                acc_off   = req_addr[1:0];
                acc_be    = 4'b0001 << req_addr[1:0];
                acc_wdata = {4{req_wdata[7:0]}};
                acc_trim  = req_unsigned ? 3'b011 : 3'b010;
            end
            2'b01: begin
                acc_off   = {req_addr[1], 1'b0};
                acc_be    = 4'b0011 << {req_addr[1], 1'b0};
                acc_wdata = {2{req_wdata[15:0]}};
                acc_trim  = req_unsigned ? 3'b100 : 3'b001;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid && !trap) state_next = ISSUE;
            ISSUE: begin
                if (timed_out)      state_next = IDLE;
                else if (mem_ready) state_next = mem_we ? IDLE : WAIT;
            end
            WAIT:    if (timed_out || mem_rvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Timeout wins over a simultaneous mem_rvalid, so a late response never produces ld_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            off         <= '0;
            trim        <= '0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_be      <= '0;
            mem_wdata   <= '0;
            ld_valid    <= 1'b0;
            ld_data     <= '0;
            ld_trim_ctl <= '0;
            err         <= 1'b0;
        end else begin
            err      <= 1'b0;
            ld_valid <= 1'b0;
            if (state != IDLE) cnt <= cnt + 8'd1;
            if (state == IDLE && req_valid) begin
                if (trap) begin
                    err <= 1'b1;
                end else begin
                    cnt       <= '0;
                    off       <= acc_off;
                    trim      <= acc_trim;
                    mem_addr  <= {req_addr[31:2], 2'b00};
                    mem_we    <= req_we;
                    mem_be    <= acc_be;
                    mem_wdata <= acc_wdata;
                end
            end
            if (timed_out) begin
                err <= 1'b1;
            end else if (state == WAIT && mem_rvalid) begin
                ld_valid    <= 1'b1;
                ld_data     <= mem_rdata >> {off, 3'b000};
                ld_trim_ctl <= trim;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (TIMEOUT=4 so the timeout path is short).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        ld_valid, busy, err;
    logic [31:0] ld_data;
    logic [2:0]  ld_trim_ctl;

    int compare_count = 0;
    int mismatch_count = 0;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_trim_ctl(ld_trim_ctl),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compare_count++;
        if (got !== exp) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one cycle; returns one cycle after acceptance
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic runLoad(input string tag, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [3:0] exp_be, input logic [31:0] exp_data,
                           input logic [2:0] exp_trim);
        applyStimulus(1'b0, size, uns, addr, 32'h0);
        checkOutput({tag, "_mem_valid"}, 32'(mem_valid), 32'd1);
        checkOutput({tag, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        checkOutput({tag, "_mem_be"}, 32'(mem_be), 32'(exp_be));
        checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        checkOutput({tag, "_wait_valid"}, 32'(mem_valid), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        mem_rvalid = 1'b0;
        checkOutput({tag, "_ld_valid"}, 32'(ld_valid), 32'd1);
        checkOutput({tag, "_ld_data"}, ld_data, exp_data);
        checkOutput({tag, "_trim"}, 32'(ld_trim_ctl), 32'(exp_trim));
        tick();
        checkOutput({tag, "_ld_pulse"}, 32'(ld_valid), 32'd0);
        checkOutput({tag, "_ld_hold"}, ld_data, exp_data);
        checkOutput({tag, "_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_mem_valid", 32'(mem_valid), 32'd0);
        checkOutput("rst_ld_valid", 32'(ld_valid), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Loads: LB, LHU, LBU with different offsets
        runLoad("lb", 2'b00, 1'b0, 32'h0000_1003, 32'h80FF_1234, 4'b1000, 32'h0000_0080, 3'b010);
        runLoad("lhu", 2'b01, 1'b1, 32'h0000_4002, 32'h8765_4321, 4'b1100, 32'h0000_8765, 3'b100);
        runLoad("lbu", 2'b00, 1'b1, 32'h0000_5001, 32'h0000_AB00, 4'b0010, 32'h0000_00AB, 3'b011);

        // SH with one cycle of backpressure
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_ABCD);
        checkOutput("sh_be", 32'(mem_be), 32'hC);
        checkOutput("sh_wdata", mem_wdata, 32'hABCD_ABCD);
        checkOutput("sh_we", 32'(mem_we), 32'd1);
        checkOutput("sh_addr", mem_addr, 32'h0000_2000);
        tick();
        checkOutput("sh_stall_valid", 32'(mem_valid), 32'd1);
        checkOutput("sh_stall_wdata", mem_wdata, 32'hABCD_ABCD);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        checkOutput("sh_busy", 32'(busy), 32'd0);
        checkOutput("sh_ready", 32'(req_ready), 32'd1);
        checkOutput("sh_no_ld", 32'(ld_valid), 32'd0);

        // SB at offset 1
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h0000_7001, 32'h1234_565A);
        checkOutput("sb_be", 32'(mem_be), 32'h2);
        checkOutput("sb_wdata", mem_wdata, 32'h5A5A_5A5A);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;

        // Timeout with mem_ready held low
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("to_valid_c%0d", i), 32'(mem_valid), 32'd1);
            checkOutput($sformatf("to_err_c%0d", i), 32'(err), 32'd0);
            tick();
        end
        checkOutput("to_err", 32'(err), 32'd1);
        checkOutput("to_valid_drop", 32'(mem_valid), 32'd0);
        checkOutput("to_busy", 32'(busy), 32'd0);
        checkOutput("to_no_ld", 32'(ld_valid), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        tick();
        mem_rvalid = 1'b0;
        checkOutput("to_err_pulse", 32'(err), 32'd0);
        checkOutput("to_late_rvalid", 32'(ld_valid), 32'd0);

        // Misaligned LW
`ifdef LSU_MISALIGN_TRAP_EN
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_1001, 32'h0);
        checkOutput("mis_err", 32'(err), 32'd1);
        checkOutput("mis_valid", 32'(mem_valid), 32'd0);
        checkOutput("mis_busy", 32'(busy), 32'd0);
        tick();
        checkOutput("mis_err_pulse", 32'(err), 32'd0);
        checkOutput("mis_valid2", 32'(mem_valid), 32'd0);
`else
        runLoad("mis_lw", 2'b10, 1'b0, 32'h0000_1001, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 3'b000);
`endif

        // Reset in WAIT, then a late mem_rvalid
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_busy", 32'(busy), 32'd0);
        checkOutput("ar_mem_addr", mem_addr, 32'd0);
        checkOutput("ar_ld_data", ld_data, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        tick();
        mem_rvalid = 1'b0;
        checkOutput("ar_ld_valid", 32'(ld_valid), 32'd0);
        checkOutput("ar_req_ready", 32'(req_ready), 32'd1);
        checkOutput("ar_ld_data2", ld_data, 32'd0);
        checkOutput("ar_trim", 32'(ld_trim_ctl), 32'd0);
        checkOutput("ar_err", 32'(err), 32'd0);
        checkOutput("ar_mem_valid", 32'(mem_valid), 32'd0);
        checkOutput("ar_mem_be", 32'(mem_be), 32'd0);
        checkOutput("ar_mem_wdata", mem_wdata, 32'd0);
        checkOutput("ar_mem_we", 32'(mem_we), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
